segre_assoc_cache: RTL and testbench

SEGRE_ASSOC_CACHE -- requirements
Module: segre_assoc_cache

---
 rtl/segre_assoc_cache.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_segre_assoc_cache.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_assoc_cache.sv
// rtl/segre_assoc_cache.sv - set-associative write-back cache with age-based victim selection
// Define SEGRE_CACHE_STATS_EN for saturating hit/miss counters; req_size_i: 0 byte, 1 half, 2 word.
module segre_assoc_cache #(
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32,
  localparam int WORD_SIZE = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [1:0]              req_size_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [WORD_SIZE-1:0]    req_wdata_i,
  output logic                    rsp_valid_o,
  output logic [WORD_SIZE-1:0]    rsp_rdata_o,
  output logic                    mem_req_valid_o,
  output logic                    mem_req_we_o,
  output logic [ADDR_W-1:0]       mem_req_addr_o,
  output logic [LINE_BYTES*8-1:0] mem_wline_o,
  input  logic                    mem_req_ready_i,
  input  logic                    mem_rsp_valid_i,
  input  logic [LINE_BYTES*8-1:0] mem_rline_i,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int BIT_W  = OFF_W + 3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL_REQ,
    REFILL_WAIT
  } state_e;

  state_e state_q, state_d;

  logic                 req_we_q;
  logic [1:0]           req_size_q;
  logic [ADDR_W-1:0]    req_addr_q;
  logic [WORD_SIZE-1:0] req_wdata_q;
  logic [WAY_W-1:0]     victim_q;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [OFF_W-1:0]     word_base;
  logic [1:0]           bsel;
  logic [WAYS-1:0]      hit_vec;
  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic [LINE_W-1:0]    hit_line;
  logic [WORD_SIZE-1:0] lookup_word;
  logic [3:0]           be;
  logic [WORD_SIZE-1:0] wdata_sh;
  logic [LINE_W-1:0]    store_line;
  logic [WAY_W-1:0]     victim_sel;
  logic                 victim_dirty;
  logic                 fill_en;
  logic                 store_en;

  assign idx       = req_addr_q[OFF_W +: IDX_W];
  assign tag       = req_addr_q[ADDR_W-1 -: TAG_W];
  assign word_base = req_addr_q[OFF_W-1:0] & ~OFF_W'(3);
  assign bsel      = req_addr_q[1:0];

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
    end
  end

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit         = |hit_vec;
  assign hit_line    = data_q[idx][hit_way];
  assign lookup_word = hit_line[{word_base, 3'b000} +: WORD_SIZE];
  assign store_en    = (state_q == LOOKUP) && hit && req_we_q;
  assign fill_en     = (state_q == REFILL_WAIT) && mem_rsp_valid_i;

  // Store data is right-aligned; shift it onto the addressed byte lanes of the word.
  always_comb begin
    case (req_size_q)
      SZ_BYTE: be = 4'b0001 << bsel;
      SZ_HALF: be = 4'b0011 << bsel;
      default: be = 4'b1111;
    endcase
    wdata_sh   = req_wdata_q << {bsel, 3'b000};
    store_line = hit_line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) store_line[{word_base, 3'b000} + BIT_W'(b * 8) +: 8] = wdata_sh[b*8 +: 8];
    end
  end

  generate
    if (WAYS > 1) begin : g_age
      logic [WAY_W-1:0] age_q [SETS][WAYS];
      logic [WAY_W-1:0] max_age;
      logic             found_inv;
      logic             upd_en;
      logic [WAY_W-1:0] upd_way;
      logic [WAY_W-1:0] ref_age;

      always_comb begin
        victim_sel = '0;
        found_inv  = 1'b0;
        max_age    = '0;
        for (int w = 0; w < WAYS; w++) begin
          if (!found_inv && !valid_q[idx][w]) begin
            victim_sel = WAY_W'(w);
            found_inv  = 1'b1;
          end
        end
        if (!found_inv) begin
          for (int w = 0; w < WAYS; w++) begin
            if (age_q[idx][w] > max_age) begin
              max_age    = age_q[idx][w];
              victim_sel = WAY_W'(w);
            end
          end
        end
      end

      // An invalid way being filled counts as the oldest, so every valid way ages.
      assign upd_en  = ((state_q == LOOKUP) && hit) || fill_en;
      assign upd_way = (state_q == LOOKUP) ? hit_way : victim_q;
      assign ref_age = valid_q[idx][upd_way] ? age_q[idx][upd_way] : WAY_W'(WAYS - 1);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
          end
        end else if (upd_en) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == upd_way) begin
              age_q[idx][w] <= '0;
            end else if (valid_q[idx][w] && (age_q[idx][w] < ref_age)) begin
              age_q[idx][w] <= age_q[idx][w] + WAY_W'(1);
            end
          end
        end
      end
    end else begin : g_no_age
      assign victim_sel = '0;
    end
  endgenerate

  assign victim_dirty = valid_q[idx][victim_sel] && dirty_q[idx][victim_sel];
  assign req_ready_o  = (state_q == IDLE) && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      req_we_q    <= 1'b0;
      req_size_q  <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      victim_q    <= '0;
    end else begin
      state_q <= state_d;
      if (req_valid_i && req_ready_o) begin
        req_we_q    <= req_we_i;
        req_size_q  <= req_size_i;
        req_addr_q  <= req_addr_i;
        req_wdata_q <= req_wdata_i;
      end
      if ((state_q == LOOKUP) && !hit) victim_q <= victim_sel;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else if (store_en) begin
      dirty_q[idx][hit_way] <= 1'b1;
    end else if (fill_en) begin
      valid_q[idx][victim_q] <= 1'b1;
      dirty_q[idx][victim_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store_en) data_q[idx][hit_way] <= store_line;
    if (fill_en) begin
      data_q[idx][victim_q] <= mem_rline_i;
      tag_q[idx][victim_q]  <= tag;
    end
  end

  always_comb begin
    state_d         = state_q;
    rsp_valid_o     = 1'b0;
    rsp_rdata_o     = '0;
    mem_req_valid_o = 1'b0;
    mem_req_we_o    = 1'b0;
    mem_req_addr_o  = '0;
    mem_wline_o     = '0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          rsp_valid_o = 1'b1;
          if (!req_we_q) rsp_rdata_o = lookup_word;
          state_d = IDLE;
        end else if (victim_dirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = REFILL_REQ;
        end
      end
      WRITEBACK: begin
        mem_req_valid_o = 1'b1;
        mem_req_we_o    = 1'b1;
        mem_req_addr_o  = {tag_q[idx][victim_q], idx, OFF_W'(0)};
        mem_wline_o     = data_q[idx][victim_q];
        if (mem_req_ready_i) state_d = REFILL_REQ;
      end
      REFILL_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = {tag, idx, OFF_W'(0)};
        if (mem_req_ready_i) state_d = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        if (mem_rsp_valid_i) state_d = LOOKUP;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SEGRE_CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        post_refill_q;

  // The lookup that follows a refill always hits; it belongs to the miss already counted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      post_refill_q <= 1'b0;
    end else begin
      if (fill_en) post_refill_q <= 1'b1;
      else if (state_q == LOOKUP) post_refill_q <= 1'b0;
      if ((state_q == LOOKUP) && hit && !post_refill_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if ((state_q == LOOKUP) && !hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_segre_assoc_cache.sv
// tb/tb_segre_assoc_cache.sv - directed table-driven bench for segre_assoc_cache
module tb_segre_assoc_cache;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic         req_we_i;
  logic [1:0]   req_size_i;
  logic [31:0]  req_addr_i;
  logic [31:0]  req_wdata_i;
  logic         rsp_valid_o;
  logic [31:0]  rsp_rdata_o;
  logic         mem_req_valid_o;
  logic         mem_req_we_o;
  logic [31:0]  mem_req_addr_o;
  logic [127:0] mem_wline_o;
  logic         mem_req_ready_i;
  logic         mem_rsp_valid_i;
  logic [127:0] mem_rline_i;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  always #5 clk_i = ~clk_i;

  segre_assoc_cache dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_we_o   (mem_req_we_o),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_wline_o    (mem_wline_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rline_i    (mem_rline_i),
    .hit_cnt_o      (hit_cnt_o),
    .miss_cnt_o     (miss_cnt_o)
  );

`ifdef SEGRE_CACHE_STATS_EN
  localparam logic [31:0] EXP_HIT  = 32'd2;
  localparam logic [31:0] EXP_MISS = 32'd1;
`else
  localparam logic [31:0] EXP_HIT  = 32'd0;
  localparam logic [31:0] EXP_MISS = 32'd0;
`endif

  localparam logic [1:0] SB = 2'd0;
  localparam logic [1:0] SH = 2'd1;
  localparam logic [1:0] SW = 2'd2;

  typedef struct {
    logic         we;
    logic [1:0]   sz;
    logic [31:0]  a;
    logic [31:0]  wd;
    logic [31:0]  rd;
    logic         hit;
    int           nwb;
    logic [31:0]  wba;
    logic [127:0] wbl;
    int           nrf;
    logic [31:0]  rfa;
  } vec_t;

  vec_t         tbl [18];
  logic [127:0] mem_m [logic [31:0]];
  int           total = 0;
  int           bad = 0;

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic hit,
                              input int nwb, input logic [31:0] wba, input logic [127:0] wbl,
                              input int nrf, input logic [31:0] rfa);
    vec_t v;
    v.we = we; v.sz = sz; v.a = a; v.wd = wd; v.rd = rd; v.hit = hit;
    v.nwb = nwb; v.wba = wba; v.wbl = wbl; v.nrf = nrf; v.rfa = rfa;
    return v;
  endfunction

  function automatic logic [127:0] mem_get(input logic [31:0] a);
    logic [127:0] l;
    if (mem_m.exists(a)) return mem_m[a];
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = (a + 32'(4 * k)) ^ 32'h5A5A_0000;
    return l;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input int dly, input logic noise,
                         output logic [31:0] rd, output int lat, output int nwb,
                         output logic [31:0] wba, output logic [127:0] wbl, output int nrf,
                         output logic [31:0] rfa, output int ovl, output int serr);
    int           hold;
    logic         pend;
    logic         done;
    logic [31:0]  ra;
    logic [127:0] rl;
    logic         rw;
    rd = '0; lat = 0; nwb = 0; wba = '0; wbl = '0; nrf = 0; rfa = '0; ovl = 0; serr = 0;
    hold = 0; pend = 1'b0; done = 1'b0; ra = '0; rl = '0; rw = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_addr_i = a; req_wdata_i = wd;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk_i);
      req_valid_i     = noise;
      req_addr_i      = noise ? 32'h0000_4230 : a;
      req_we_i        = noise ? 1'b1 : we;
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b0;
      lat++;
      if (rsp_valid_o && mem_req_valid_o) ovl++;
      if (rsp_valid_o) begin
        rd          = rsp_rdata_o;
        done        = 1'b1;
        req_valid_i = 1'b0;
      end else if (mem_req_valid_o) begin
        if (hold == 0) begin
          ra = mem_req_addr_o; rl = mem_wline_o; rw = mem_req_we_o;
        end else if (mem_req_addr_o !== ra || mem_wline_o !== rl || mem_req_we_o !== rw ||
                     req_ready_o !== 1'b0) begin
          serr++;
        end
        if (hold >= dly) begin
          mem_req_ready_i = 1'b1;
          hold = 0;
          if (mem_req_we_o) begin
            nwb++; wba = mem_req_addr_o; wbl = mem_wline_o; mem_m[wba] = wbl;
          end else begin
            nrf++; rfa = mem_req_addr_o; pend = 1'b1;
          end
        end else begin
          hold++;
        end
      end else if (pend) begin
        mem_rsp_valid_i = 1'b1;
        mem_rline_i     = mem_get(rfa);
        pend            = 1'b0;
      end
    end
    req_valid_i = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout: no response for addr %h", a);
    end
  endtask

  initial begin
    logic [31:0]  rd, wba, rfa;
    logic [127:0] wbl;
    int           lat, nwb, nrf, ovl, serr;

    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = SW;
    req_addr_i = '0; req_wdata_i = '0; mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0; mem_rline_i = '0;
    mem_m[32'h100] = {32'h4433_2211, 32'h8877_6655, 32'hCCBB_AA99, 32'hDDCC_BBAA};

    tbl[0]  = mk(0, SW, 32'h100,  0,            32'hDDCC_BBAA, 0, 0, 0, 0, 1, 32'h100);
    tbl[1]  = mk(1, SB, 32'h101,  32'h5A,       32'h0,         1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, SW, 32'h100,  0,            32'hDDCC_5AAA, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, SW, 32'h200,  0,            32'h5A5A_0200, 0, 0, 0, 0, 1, 32'h200);
    tbl[4]  = mk(0, SW, 32'h10C,  0,            32'h4433_2211, 1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, SW, 32'h300,  0,            32'h5A5A_0300, 0, 0, 0, 0, 1, 32'h300);
    tbl[6]  = mk(1, SW, 32'h104,  32'hCAFE_F00D, 32'h0,        1, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, SH, 32'h306,  0,            32'h5A5A_0304, 1, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, SW, 32'h400,  0,            32'h5A5A_0400, 0, 1, 32'h100,
                 {32'h4433_2211, 32'h8877_6655, 32'hCAFE_F00D, 32'hDDCC_5AAA}, 1, 32'h400);
    tbl[9]  = mk(0, SW, 32'h100,  0,            32'hDDCC_5AAA, 0, 0, 0, 0, 1, 32'h100);
    tbl[10] = mk(0, SB, 32'h107,  0,            32'hCAFE_F00D, 1, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, SW, 32'h1234, 0,            32'h5A5A_1234, 0, 0, 0, 0, 1, 32'h1230);
    tbl[12] = mk(1, SH, 32'h1236, 32'hBEEF,     32'h0,         1, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, SW, 32'h1234, 0,            32'hBEEF_1234, 1, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, SW, 32'h1238, 32'h0102_0304, 32'h0,        1, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, SW, 32'h1238, 0,            32'h0102_0304, 1, 0, 0, 0, 0, 0);
    tbl[16] = mk(1, SH, 32'h1230, 32'hFFFF_ABCD, 32'h0,        1, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, SW, 32'h1230, 0,            32'h5A5A_ABCD, 1, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk_i);
    chk("rst req_ready", req_ready_o, 1'b0);
    chk("rst rsp_valid", rsp_valid_o, 1'b0);
    chk("rst mem_req_valid", mem_req_valid_o, 1'b0);
    chk("rst hit_cnt", hit_cnt_o, 32'd0);
    chk("rst miss_cnt", miss_cnt_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post-rst req_ready", req_ready_o, 1'b1);

    for (int i = 0; i < 18; i++) begin
      run_req(tbl[i].we, tbl[i].sz, tbl[i].a, tbl[i].wd, 0, 1'b0,
              rd, lat, nwb, wba, wbl, nrf, rfa, ovl, serr);
      chk($sformatf("v%0d rdata", i), rd, tbl[i].rd);
      chk($sformatf("v%0d hit", i), lat == 1, tbl[i].hit);
      chk($sformatf("v%0d writebacks", i), nwb, tbl[i].nwb);
      if (tbl[i].nwb != 0) begin
        chk($sformatf("v%0d wb addr", i), wba, tbl[i].wba);
        chk($sformatf("v%0d wb line", i), wbl, tbl[i].wbl);
      end
      chk($sformatf("v%0d refills", i), nrf, tbl[i].nrf);
      if (tbl[i].nrf != 0) chk($sformatf("v%0d refill addr", i), rfa, tbl[i].rfa);
      chk($sformatf("v%0d rsp/mem overlap", i), ovl, 0);
      if (i == 2) begin
        chk("stats hit_cnt", hit_cnt_o, EXP_HIT);
        chk("stats miss_cnt", miss_cnt_o, EXP_MISS);
      end
    end

    // Writeback held off by memory for 5 cycles while new requests are offered.
    run_req(0, SW, 32'h2230, 0, 0, 1'b0, rd, lat, nwb, wba, wbl, nrf, rfa, ovl, serr);
    chk("fill way1 set3 rdata", rd, 32'h5A5A_2230);
    run_req(0, SW, 32'h3230, 0, 5, 1'b1, rd, lat, nwb, wba, wbl, nrf, rfa, ovl, serr);
    chk("stall stability", serr, 0);
    chk("stall wb addr", wba, 32'h1230);
    chk("stall wb line", wbl, {32'h5A5A_123C, 32'h0102_0304, 32'hBEEF_1234, 32'h5A5A_ABCD});
    chk("stall rdata", rd, 32'h5A5A_3230);
    chk("stall refill addr", rfa, 32'h3230);

    // Reset in REFILL_WAIT.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = SW; req_addr_i = 32'h500;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rr valid", mem_req_valid_o, 1'b1);
    chk("rr addr", mem_req_addr_o, 32'h500);
    mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    mem_req_ready_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("midrst req_ready", req_ready_o, 1'b0);
    chk("midrst rsp_valid", rsp_valid_o, 1'b0);
    chk("midrst rdata", rsp_rdata_o, 32'd0);
    chk("midrst mem_valid", mem_req_valid_o, 1'b0);
    chk("midrst mem_we", mem_req_we_o, 1'b0);
    chk("midrst mem_addr", mem_req_addr_o, 32'd0);
    chk("midrst wline", mem_wline_o, 128'd0);
    chk("midrst hit_cnt", hit_cnt_o, 32'd0);
    chk("midrst miss_cnt", miss_cnt_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("after midrst req_ready", req_ready_o, 1'b1);
    run_req(0, SW, 32'h500, 0, 0, 1'b0, rd, lat, nwb, wba, wbl, nrf, rfa, ovl, serr);
    chk("reload miss", lat == 1, 1'b0);
    chk("reload refills", nrf, 1);
    chk("reload rdata", rd, 32'h5A5A_0500);

    // Stray refill data while idle must not disturb the cache.
    @(negedge clk_i);
    mem_rsp_valid_i = 1'b1; mem_rline_i = '1;
    @(negedge clk_i);
    mem_rsp_valid_i = 1'b0;
    run_req(0, SW, 32'h500, 0, 0, 1'b0, rd, lat, nwb, wba, wbl, nrf, rfa, ovl, serr);
    chk("stray rsp hit", lat == 1, 1'b1);
    chk("stray rsp rdata", rd, 32'h5A5A_0500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
